// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer.
// Holds the instruction field widths, the state encodings, the supported
// opcode constants and the bit positions of the latched control word.
package mips_multicycle_ctrl_pkg;

    localparam int OPCODE_WIDTH = 6;
    localparam int FUNCT_WIDTH  = 6;

    // State encodings are visible on c_o_state, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd7
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'h2B;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'h08;

    // Control word bit positions. needs_mem/needs_wb choose the path after
    // EXECUTE and together also identify lw, sw and beq.
    localparam int CW_REG_DST    = 0;
    localparam int CW_ALU_SRC    = 1;
    localparam int CW_MEM_TO_REG = 2;
    localparam int CW_NEEDS_MEM  = 3;
    localparam int CW_NEEDS_WB   = 4;
    localparam int CW_WIDTH      = 5;

endpackage

// File: rtl/mips_multicycle_ctrl_decode.sv
// Combinational opcode decoder for the multi-cycle control sequencer.
// Ports:
//   i_opcode      : opcode from the datapath decoder stage
//   o_legal       : opcode is one of R-type, lw, sw, beq, addi
//   o_reg_dst     : destination register comes from rd (R-type)
//   o_alu_src     : ALU B operand is the immediate
//   o_mem_to_reg  : write-back data comes from memory (lw)
//   o_needs_mem   : instruction visits MEMORY (lw, sw)
//   o_needs_wb    : instruction visits WRITEBACK (R-type, addi, lw)
// Illegal opcodes decode to all zeros.
module mips_multicycle_ctrl_decode
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    output logic                    o_legal,
    output logic                    o_reg_dst,
    output logic                    o_alu_src,
    output logic                    o_mem_to_reg,
    output logic                    o_needs_mem,
    output logic                    o_needs_wb
);

    always_comb begin
        o_legal      = 1'b0;
        o_reg_dst    = 1'b0;
        o_alu_src    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_needs_mem  = 1'b0;
        o_needs_wb   = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_legal    = 1'b1;
                o_reg_dst  = 1'b1;
                o_needs_wb = 1'b1;
            end
            OP_ADDI: begin
                o_legal    = 1'b1;
                o_alu_src  = 1'b1;
                o_needs_wb = 1'b1;
            end
            OP_LW: begin
                o_legal      = 1'b1;
                o_alu_src    = 1'b1;
                o_mem_to_reg = 1'b1;
                o_needs_mem  = 1'b1;
                o_needs_wb   = 1'b1;
            end
            OP_SW: begin
                o_legal     = 1'b1;
                o_alu_src   = 1'b1;
                o_needs_mem = 1'b1;
            end
            OP_BEQ: begin
                o_legal = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control sequencer for the single-issue MIPS datapath.
// Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and
// WRITEBACK, drives the datapath strobes, counts retired instructions and
// traps (stickily) on illegal opcodes.
// Ports:
//   c_clk, c_rst        : clock, asynchronous active-low reset
//   c_i_run             : level enable, sampled in IDLE and at the last
//                         state of each instruction
//   c_i_opcode/funct    : instruction fields, valid during DECODE
//   c_o_ce              : fetch enable (FETCH only)
//   c_o_reg_dst .. c_o_mem_to_reg : datapath controls
//   c_o_state           : current state encoding
//   c_o_busy            : not IDLE and not TRAP
//   c_o_trap            : sticky illegal-opcode flag
//   c_o_retired         : retired-instruction count (wraps)
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
)
(
    input  logic                    c_clk,
    input  logic                    c_rst,
    input  logic                    c_i_run,
    input  logic [OPCODE_WIDTH-1:0] c_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]  c_i_funct,
    output logic                    c_o_ce,
    output logic                    c_o_reg_dst,
    output logic                    c_o_reg_write,
    output logic                    c_o_alu_src,
    output logic                    c_o_branch,
    output logic                    c_o_mem_read,
    output logic                    c_o_mem_write,
    output logic                    c_o_mem_to_reg,
    output logic [2:0]              c_o_state,
    output logic                    c_o_busy,
    output logic                    c_o_trap,
    output logic [CNT_WIDTH-1:0]    c_o_retired
);

    state_t                r_state;
    logic [CW_WIDTH-1:0]   r_cw;
    logic                  r_trap;
    logic [CNT_WIDTH-1:0]  r_retired;

    logic                  w_legal;
    logic [CW_WIDTH-1:0]   w_cw;
    state_t                w_after_last;
    logic                  w_in_exec_phase;
    logic                  w_is_lw;
    logic                  w_is_sw;
    logic                  w_is_beq;

    // R-type funct is not checked; the port exists for datapath symmetry.
    logic w_unused_funct;
    assign w_unused_funct = ^c_i_funct;

    mips_multicycle_ctrl_decode u_decode (
        .i_opcode     (c_i_opcode),
        .o_legal      (w_legal),
        .o_reg_dst    (w_cw[CW_REG_DST]),
        .o_alu_src    (w_cw[CW_ALU_SRC]),
        .o_mem_to_reg (w_cw[CW_MEM_TO_REG]),
        .o_needs_mem  (w_cw[CW_NEEDS_MEM]),
        .o_needs_wb   (w_cw[CW_NEEDS_WB])
    );

    // Where every instruction goes after its final state.
    assign w_after_last = c_i_run ? ST_FETCH : ST_IDLE;

    always_ff @(posedge c_clk or negedge c_rst) begin
        if (!c_rst) begin
            r_state   <= ST_IDLE;
            r_cw      <= '0;
            r_trap    <= 1'b0;
            r_retired <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (c_i_run) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    // Illegal opcodes decode to zero, so the held word is inert.
                    r_cw <= w_cw;
                    if (w_legal) begin
                        r_state <= ST_EXECUTE;
                    end else begin
                        r_state <= ST_TRAP;
                        r_trap  <= 1'b1;
                    end
                end
                ST_EXECUTE: begin
                    if (r_cw[CW_NEEDS_MEM]) begin
                        r_state <= ST_MEMORY;
                    end else if (r_cw[CW_NEEDS_WB]) begin
                        r_state <= ST_WRITEBACK;
                    end else begin
                        r_state   <= w_after_last;
                        r_retired <= r_retired + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_MEMORY: begin
                    if (r_cw[CW_NEEDS_WB]) begin
                        r_state <= ST_WRITEBACK;
                    end else begin
                        r_state   <= w_after_last;
                        r_retired <= r_retired + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_WRITEBACK: begin
                    r_state   <= w_after_last;
                    r_retired <= r_retired + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
                ST_TRAP: begin
                    r_state <= ST_TRAP;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Instruction class recovered from the path bits of the held word.
    assign w_is_lw  =  r_cw[CW_NEEDS_MEM] &  r_cw[CW_NEEDS_WB];
    assign w_is_sw  =  r_cw[CW_NEEDS_MEM] & ~r_cw[CW_NEEDS_WB];
    assign w_is_beq = ~r_cw[CW_NEEDS_MEM] & ~r_cw[CW_NEEDS_WB];

    assign w_in_exec_phase = (r_state == ST_EXECUTE) || (r_state == ST_MEMORY) ||
                             (r_state == ST_WRITEBACK);

    assign c_o_ce         = (r_state == ST_FETCH);
    assign c_o_branch     = (r_state == ST_EXECUTE) & w_is_beq;
    assign c_o_mem_write  = (r_state == ST_MEMORY) & w_is_sw;
    assign c_o_mem_read   = ((r_state == ST_MEMORY) || (r_state == ST_WRITEBACK)) & w_is_lw;
    assign c_o_reg_write  = (r_state == ST_WRITEBACK);
    assign c_o_reg_dst    = w_in_exec_phase & r_cw[CW_REG_DST];
    assign c_o_alu_src    = w_in_exec_phase & r_cw[CW_ALU_SRC];
    assign c_o_mem_to_reg = w_in_exec_phase & r_cw[CW_MEM_TO_REG];

    assign c_o_state   = r_state;
    assign c_o_busy    = (r_state != ST_IDLE) && (r_state != ST_TRAP);
    assign c_o_trap    = r_trap;
    assign c_o_retired = r_retired;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl. Strobes are compared as one
// vector: {ce, reg_dst, reg_write, alu_src, branch, mem_read, mem_write,
// mem_to_reg}. A second instance with a 4-bit counter checks wrap-around.
module tb_mips_multicycle_ctrl;

    logic       c_clk = 1'b0;
    logic       c_rst = 1'b0;
    logic       c_i_run = 1'b0;
    logic [5:0] c_i_opcode = 6'h00;
    logic [5:0] c_i_funct = 6'h20;

    logic       c_o_ce, c_o_reg_dst, c_o_reg_write, c_o_alu_src, c_o_branch;
    logic       c_o_mem_read, c_o_mem_write, c_o_mem_to_reg;
    logic [2:0] c_o_state;
    logic       c_o_busy, c_o_trap;
    logic [31:0] c_o_retired;

    // Small-counter instance
    logic       w4_run = 1'b0;
    logic [5:0] w4_opcode = 6'h08;
    logic       w4_ce, w4_reg_dst, w4_reg_write, w4_alu_src, w4_branch;
    logic       w4_mem_read, w4_mem_write, w4_mem_to_reg;
    logic [2:0] w4_state;
    logic       w4_busy, w4_trap;
    logic [3:0] w4_retired;

    logic [7:0] w_strb;
    assign w_strb = {c_o_ce, c_o_reg_dst, c_o_reg_write, c_o_alu_src,
                     c_o_branch, c_o_mem_read, c_o_mem_write, c_o_mem_to_reg};

    int n_checks = 0;
    int n_fails  = 0;

    always #5 c_clk = ~c_clk;

    mips_multicycle_ctrl #(.CNT_WIDTH(32)) dut (
        .c_clk(c_clk), .c_rst(c_rst), .c_i_run(c_i_run),
        .c_i_opcode(c_i_opcode), .c_i_funct(c_i_funct),
        .c_o_ce(c_o_ce), .c_o_reg_dst(c_o_reg_dst), .c_o_reg_write(c_o_reg_write),
        .c_o_alu_src(c_o_alu_src), .c_o_branch(c_o_branch),
        .c_o_mem_read(c_o_mem_read), .c_o_mem_write(c_o_mem_write),
        .c_o_mem_to_reg(c_o_mem_to_reg), .c_o_state(c_o_state),
        .c_o_busy(c_o_busy), .c_o_trap(c_o_trap), .c_o_retired(c_o_retired)
    );

    mips_multicycle_ctrl #(.CNT_WIDTH(4)) dut4 (
        .c_clk(c_clk), .c_rst(c_rst), .c_i_run(w4_run),
        .c_i_opcode(w4_opcode), .c_i_funct(c_i_funct),
        .c_o_ce(w4_ce), .c_o_reg_dst(w4_reg_dst), .c_o_reg_write(w4_reg_write),
        .c_o_alu_src(w4_alu_src), .c_o_branch(w4_branch),
        .c_o_mem_read(w4_mem_read), .c_o_mem_write(w4_mem_write),
        .c_o_mem_to_reg(w4_mem_to_reg), .c_o_state(w4_state),
        .c_o_busy(w4_busy), .c_o_trap(w4_trap), .c_o_retired(w4_retired)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    // One clock, then compare state and strobe vector.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [7:0] sb);
        tick();
        chk({tag, "_state"}, 32'(c_o_state), 32'(st));
        chk({tag, "_strb"}, 32'(w_strb), 32'(sb));
    endtask

    initial begin
        logic [7:0] seen;
        logic       left_trap;

        // ---------------- reset state ----------------
        #2;
        chk("rst_strb", 32'(w_strb), 32'h0);
        chk("rst_state", 32'(c_o_state), 32'h0);
        chk("rst_busy", 32'(c_o_busy), 32'h0);
        chk("rst_trap", 32'(c_o_trap), 32'h0);
        chk("rst_retired", c_o_retired, 32'h0);
        #10 c_rst = 1'b1;
        cyc("idle0", 3'd0, 8'h00);
        chk("idle0_busy", 32'(c_o_busy), 32'h0);
        $display("[%0t] reset released, idle", $time);

        // ---------------- R-type, run dropped mid-instruction ----------------
        c_i_opcode = 6'h00;
        c_i_run = 1'b1;
        cyc("r_c1", 3'd1, 8'h80);
        chk("r_c1_busy", 32'(c_o_busy), 32'h1);
        c_i_run = 1'b0;
        cyc("r_c2", 3'd2, 8'h00);
        cyc("r_c3", 3'd3, 8'h40);
        cyc("r_c4", 3'd5, 8'h60);
        chk("r_c4_retired", c_o_retired, 32'd0);
        cyc("r_end", 3'd0, 8'h00);
        chk("r_retired", c_o_retired, 32'd1);
        $display("[%0t] R-type retired=%0d", $time, c_o_retired);

        // ---------------- lw then sw back-to-back ----------------
        c_i_opcode = 6'h23;
        c_i_run = 1'b1;
        cyc("lw_c1", 3'd1, 8'h80);
        cyc("lw_c2", 3'd2, 8'h00);
        cyc("lw_c3", 3'd3, 8'h11);
        cyc("lw_c4", 3'd4, 8'h15);
        c_i_opcode = 6'h2B;
        cyc("lw_c5", 3'd5, 8'h35);
        cyc("sw_c6", 3'd1, 8'h80);
        chk("lw_retired", c_o_retired, 32'd2);
        $display("[%0t] lw retired=%0d", $time, c_o_retired);
        cyc("sw_c7", 3'd2, 8'h00);
        c_i_run = 1'b0;
        cyc("sw_c8", 3'd3, 8'h10);
        cyc("sw_c9", 3'd4, 8'h12);
        cyc("sw_end", 3'd0, 8'h00);
        chk("sw_retired", c_o_retired, 32'd3);
        $display("[%0t] sw retired=%0d", $time, c_o_retired);

        // ---------------- beq, then straight into an illegal opcode ----------------
        c_i_opcode = 6'h04;
        c_i_run = 1'b1;
        cyc("beq_c1", 3'd1, 8'h80);
        cyc("beq_c2", 3'd2, 8'h00);
        cyc("beq_c3", 3'd3, 8'h08);
        c_i_opcode = 6'h3F;
        cyc("beq_c4", 3'd1, 8'h80);
        chk("beq_retired", c_o_retired, 32'd4);
        $display("[%0t] beq retired=%0d", $time, c_o_retired);

        cyc("ill_dec", 3'd2, 8'h00);
        chk("ill_dec_trap", 32'(c_o_trap), 32'h0);
        cyc("ill_trap", 3'd7, 8'h00);
        chk("ill_trap_flag", 32'(c_o_trap), 32'h1);
        chk("ill_busy", 32'(c_o_busy), 32'h0);
        seen = 8'h00;
        left_trap = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | w_strb;
            if (c_o_state != 3'd7 || c_o_trap != 1'b1) left_trap = 1'b1;
        end
        chk("trap_strobes", 32'(seen), 32'h0);
        chk("trap_sticky", 32'(left_trap), 32'h0);
        chk("trap_retired", c_o_retired, 32'd4);
        $display("[%0t] illegal opcode trapped, retired=%0d", $time, c_o_retired);

        c_rst = 1'b0;
        #2;
        chk("trap_clr_flag", 32'(c_o_trap), 32'h0);
        chk("trap_clr_state", 32'(c_o_state), 32'h0);
        c_i_run = 1'b0;
        #4 c_rst = 1'b1;
        $display("[%0t] trap cleared by reset", $time);

        // ---------------- reset mid-EXECUTE of an R-type ----------------
        c_i_opcode = 6'h00;
        c_i_run = 1'b1;
        cyc("rr_c1", 3'd1, 8'h80);
        cyc("rr_c2", 3'd2, 8'h00);
        cyc("rr_c3", 3'd3, 8'h40);
        c_rst = 1'b0;
        #1;
        chk("rr_rst_strb", 32'(w_strb), 32'h0);
        chk("rr_rst_state", 32'(c_o_state), 32'h0);
        chk("rr_rst_busy", 32'(c_o_busy), 32'h0);
        chk("rr_rst_retired", c_o_retired, 32'h0);
        c_i_run = 1'b0;
        #3 c_rst = 1'b1;
        cyc("rr_idle1", 3'd0, 8'h00);
        cyc("rr_idle2", 3'd0, 8'h00);
        chk("rr_idle_busy", 32'(c_o_busy), 32'h0);
        $display("[%0t] reset mid-EXECUTE, idle after release", $time);

        // ---------------- counter wrap with a 4-bit counter ----------------
        w4_opcode = 6'h08;
        w4_run = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 4) begin
                chk("wrap_first_state", 32'(w4_state), 32'd5);
                chk("wrap_first_strb", 32'({w4_alu_src, w4_reg_write, w4_reg_dst}), 32'b110);
            end
        end
        chk("wrap_last_state", 32'(w4_state), 32'd5);
        chk("wrap_pre", 32'(w4_retired), 32'd15);
        w4_run = 1'b0;
        tick();
        chk("wrap_idle", 32'(w4_state), 32'd0);
        chk("wrap_zero", 32'(w4_retired), 32'd0);
        $display("[%0t] 16 addi on 4-bit counter, retired=%0d", $time, w4_retired);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
